// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit between decode/control and data memory.
//
// Takes the decoder's memory controls (MemRead, MemWrite, Loadop, Saveop),
// an effective byte address and right-justified store data. Classifies the
// request (illegal op, misaligned, or a real access), drives a req/ack
// handshake with word-addressed data memory using byte enables, and returns
// sign/zero-extended load data. A bounded wait turns a missing ack into a
// bus error after TIMEOUT request cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid            request strobe, taken only while busy=0
//   MemRead, MemWrite   load / store request
//   Loadop[2:0]         000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, else none
//   Saveop[1:0]         00 SW, 01 SB, 10 SH, 11 none
//   addr[31:0]          effective byte address
//   wdata[31:0]         store data, right-justified
//   busy                access in progress (state != IDLE)
//   done                one-cycle completion pulse
//   rdata[31:0]         extended load result, held until the next load
//   misalign, bus_err   fault flags, valid with done
//   mem_req .. mem_wdata  memory request bundle, stable while mem_req=1
//   mem_ack, mem_rdata  memory acknowledge and read data
// -----------------------------------------------------------------------------
module lsu #(
  parameter int unsigned TIMEOUT = 255  // max mem_req cycles without ack, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Loadop,
  input  logic [1:0]  Saveop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            is_load;
  logic [2:0]      lop;
  logic [1:0]      lane;

  // Request decode, only meaningful in IDLE with op_valid.
  logic        req_any, illegal, unaligned, accept, timed_out;
  size_t       size;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign req_any   = MemRead | MemWrite;
  assign illegal   = (MemRead & MemWrite) | (MemRead & (Loadop > 3'd4))
                   | (MemWrite & (Saveop == 2'b11));
  assign accept    = (state == IDLE) & op_valid & req_any;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  // NOTE: every signal driven in always_comb gets a default first, otherwise
  // an uncovered path holds the old value and synthesis infers a latch.
  always_comb begin
    size = SZ_W;
    if (MemRead) begin
      case (Loadop)
        3'b001, 3'b010: size = SZ_B;
        3'b011, 3'b100: size = SZ_H;
        default:        size = SZ_W;
      endcase
    end else begin
      case (Saveop)
        2'b01:   size = SZ_B;
        2'b10:   size = SZ_H;
        default: size = SZ_W;
      endcase
    end

    unaligned = ((size == SZ_W) && (addr[1:0] != 2'b00))
             || ((size == SZ_H) && addr[0]);

    case (size)
      SZ_B:    begin be = 4'b0001 << addr[1:0];             wd = {4{wdata[7:0]}};  end
      SZ_H:    begin be = addr[1] ? 4'b1100 : 4'b0011;      wd = {2{wdata[15:0]}}; end
      default: begin be = 4'b1111;                          wd = wdata;            end
    endcase
  end

  // Lane selection for load data, using the lane captured at accept time.
  always_comb begin
    byte_sel = mem_rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lop)
      3'b001:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_ext = {24'd0, byte_sel};
      3'b011:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // ---- FSM: state register ----
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (illegal | unaligned) ? RESP : ACCESS;
      ACCESS:  if (mem_ack | timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs decoded straight from the state flops ----
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == RESP);
    mem_req = (state == ACCESS);
  end

  // Datapath registers. Fault flags are rewritten every cycle so they are
  // high only in the RESP cycle that carries done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      rdata     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      is_load   <= 1'b0;
      lop       <= '0;
      lane      <= '0;
      cnt       <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus_err  <= illegal;
          misalign <= ~illegal & unaligned;
          if (!illegal && !unaligned) begin
            mem_we    <= MemWrite;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wd;
            is_load   <= MemRead;
            lop       <= Loadop;
            lane      <= addr[1:0];
            cnt       <= '0;
          end
        end
        ACCESS: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (mem_ack) begin
            if (is_load) rdata <= load_ext;
          end else if (timed_out) begin
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the decode/control stage and data memory. Consumes the decoder's memory-control outputs (MemRead, MemWrite, Loadop, Saveop) with an effective address and store data. Performs alignment checks, byte-lane steering and load sign/zero extension, and runs a req/ack handshake with data memory under a bounded-wait timeout. Asserts busy so the pipeline stalls while an access is outstanding.

## Interface
- TIMEOUT, 255: maximum cycles mem_req stays high waiting for mem_ack (≥2).
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- op_valid  in  1  request strobe; accepted only while busy=0
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Loadop  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 111 none
- Saveop  in  2  00 SW, 01 SB, 10 SH, 11 none
- addr  in  32  effective byte address
- wdata  in  32  store data (rt value, right-justified)
- busy  out  1  access in progress (state≠IDLE)
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, held until next load completes
- misalign  out  1  with done: alignment fault, no memory access
- bus_err  out  1  with done: illegal op or timeout
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit k = byte addr[1:0]==k (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory accepted write / returned read data this cycle
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- All outputs registered. Reset value of every output: 0.
- States: IDLE, ACCESS, RESP.
- IDLE: on op_valid, sample inputs, classify:
  - MemRead&MemWrite, MemRead with Loadop∉{000..100}, MemWrite with Saveop=11 → RESP, bus_err=1.
  - LW/SW with addr[1:0]≠0, LH/LHU/SH with addr[0]≠0 → RESP, misalign=1.
  - Neither MemRead nor MemWrite → no action, stay IDLE.
  - Otherwise → ACCESS: drive mem_req=1, mem_we=MemWrite, mem_addr, mem_be, mem_wdata; timeout counter=0.
- Byte enables: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU addr[1]?1100:0011; SW/LW 1111.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- ACCESS: mem_req and all mem_* held stable. mem_ack=1 → RESP; loads capture selected lane of mem_rdata into rdata (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word). No ack and counter==TIMEOUT-1 → RESP, bus_err=1, rdata unchanged. Else counter+1.
- RESP: done=1 for one cycle (with misalign/bus_err as classified), mem_req=0, → IDLE.
- op_valid outside IDLE ignored; mem_ack outside ACCESS ignored.

## Timing
- Accept edge (cycle 0) → mem_req high from cycle 1.
- Ack sampled at cycle n edge → mem_req low, done=1, rdata valid in cycle n+1; busy low cycle n+2. Minimum op_valid→done: 2 cycles.
- Fault path: op_valid cycle 0 → done+flag cycle 1, mem_req never asserted.
- Timeout: mem_req high exactly TIMEOUT cycles; ack in final cycle wins over timeout.
- Back-to-back: next op_valid accepted in the cycle busy=0 (earliest cycle after done).
- rst_n low at any time: immediate return to IDLE, mem_req and all outputs 0 asynchronously; late mem_ack after reset ignored.

## Test plan
- LB addr=0x1003, mem_rdata=0x80FF_FF00, ack in 1st ACCESS cycle → mem_be=1000, done cycle 2, rdata=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH addr=0x2002, wdata=0x1234_ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x2000; ack after 5 cycles → done 1 cycle after ack.
- LW addr=0x0006 → misalign=1 with done in cycle 1, mem_req stays 0; SH addr=0x0001 same.
- TIMEOUT=4, LW never acked → mem_req high 4 cycles, then done+bus_err=1, rdata unchanged; repeat with ack in 4th cycle → no bus_err, rdata loaded.
- MemRead=MemWrite=1 → done+bus_err next cycle, no mem_req; op_valid during ACCESS ignored.
- rst_n low while mem_req=1 → mem_req=0 immediately; mem_ack pulse after release has no effect, done stays 0.
